// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller/sequencer: six-state one-hot ring counter plus a halt state,
// decoding the opcode nibble into the 12-bit control word for the datapath.
module sap1_controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       CLK,
  input  logic       CLR_bar,
  input  logic       RUN,
  input  logic [3:0] instruction,
  output logic       Cp,
  output logic       Ep,
  output logic       L_M_bar,
  output logic       CE_bar,
  output logic       L_I_bar,
  output logic       E_I_bar,
  output logic       L_A_bar,
  output logic       E_A,
  output logic       S_U,
  output logic       E_U,
  output logic       L_B_bar,
  output logic       L_O_bar,
  output logic       HLT,
  output logic [5:0] T_state
);

  // One-hot encoding; the low six bits double as the T_state ring display.
  typedef enum logic [6:0] {
    S_T1     = 7'b0000001,
    S_T2     = 7'b0000010,
    S_T3     = 7'b0000100,
    S_T4     = 7'b0001000,
    S_T5     = 7'b0010000,
    S_T6     = 7'b0100000,
    S_HALTED = 7'b1000000
  } state_t;

  state_t state;
  state_t next_state;

  always_ff @(posedge CLK) begin
    if (!CLR_bar) state <= S_T1;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_T1:     if (RUN) next_state = S_T2;
      S_T2:     if (RUN) next_state = S_T3;
      S_T3:     if (RUN) next_state = S_T4;
      S_T4:     if (RUN) next_state = (instruction == OP_HLT) ? S_HALTED : S_T5;
      S_T5:     if (RUN) next_state = S_T6;
      S_T6:     if (RUN) next_state = S_T1;
      S_HALTED: next_state = S_HALTED;
      default:  next_state = S_T1;
    endcase
  end

  assign T_state = state[5:0];

  // RUN=0 freezes the ring and forces every control line inactive; the halt
  // indication in T4 is also gated by RUN since the halt only happens on an advance.
  always_comb begin
    Cp      = 1'b0;
    Ep      = 1'b0;
    L_M_bar = 1'b1;
    CE_bar  = 1'b1;
    L_I_bar = 1'b1;
    E_I_bar = 1'b1;
    L_A_bar = 1'b1;
    E_A     = 1'b0;
    S_U     = 1'b0;
    E_U     = 1'b0;
    L_B_bar = 1'b1;
    L_O_bar = 1'b1;
    HLT     = (state == S_HALTED);
    if (RUN) begin
      case (state)
        S_T1: begin
          Ep      = 1'b1;
          L_M_bar = 1'b0;
        end
        S_T2: Cp = 1'b1;
        S_T3: begin
          CE_bar  = 1'b0;
          L_I_bar = 1'b0;
        end
        S_T4: begin
          if (instruction == OP_LDA || instruction == OP_ADD || instruction == OP_SUB) begin
            E_I_bar = 1'b0;
            L_M_bar = 1'b0;
          end else if (instruction == OP_OUT) begin
            E_A     = 1'b1;
            L_O_bar = 1'b0;
          end else if (instruction == OP_HLT) begin
            HLT = 1'b1;
          end
        end
        S_T5: begin
          if (instruction == OP_LDA) begin
            CE_bar  = 1'b0;
            L_A_bar = 1'b0;
          end else if (instruction == OP_ADD || instruction == OP_SUB) begin
            CE_bar  = 1'b0;
            L_B_bar = 1'b0;
            S_U     = (instruction == OP_SUB);
          end
        end
        S_T6: begin
          if (instruction == OP_ADD || instruction == OP_SUB) begin
            E_U     = 1'b1;
            L_A_bar = 1'b0;
            S_U     = (instruction == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Bench for sap1_controller_sequencer: directed instruction sequences followed by
// random traffic, all compared against a table-driven behavioural model.
module tb_sap1_controller_sequencer;

  logic       CLK = 1'b0;
  logic       CLR_bar;
  logic       RUN;
  logic [3:0] instruction;
  logic       Cp, Ep, L_M_bar, CE_bar, L_I_bar, E_I_bar, L_A_bar;
  logic       E_A, S_U, E_U, L_B_bar, L_O_bar, HLT;
  logic [5:0] T_state;

  int total = 0;
  int bad   = 0;

  // Model state: ring position 1..6 and halted flag.
  int m_t      = 1;
  bit m_halted = 1'b0;

  sap1_controller_sequencer dut (
    .CLK(CLK), .CLR_bar(CLR_bar), .RUN(RUN), .instruction(instruction),
    .Cp(Cp), .Ep(Ep), .L_M_bar(L_M_bar), .CE_bar(CE_bar), .L_I_bar(L_I_bar),
    .E_I_bar(E_I_bar), .L_A_bar(L_A_bar), .E_A(E_A), .S_U(S_U), .E_U(E_U),
    .L_B_bar(L_B_bar), .L_O_bar(L_O_bar), .HLT(HLT), .T_state(T_state)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0d halted=%0d run=%0b instr=%b) at %0t",
               tag, observed, expected, m_t, m_halted, RUN, instruction, $time);
    end
  endtask

  // Expected {Cp,Ep,L_M_bar,CE_bar,L_I_bar,E_I_bar,L_A_bar,E_A,S_U,E_U,L_B_bar,L_O_bar,HLT}
  // derived from the microinstruction table; the asserted lines are listed by name.
  function automatic logic [12:0] model_word(int t, bit halted, bit run, logic [3:0] op);
    bit cp = 0, ep = 0, lm = 0, ce = 0, li = 0, ei = 0, la = 0, ea = 0, su = 0, eu = 0, lb = 0, lo = 0, h = 0;
    if (halted) h = 1;
    else if (run) begin
      if (t == 1) begin ep = 1; lm = 1; end
      if (t == 2) cp = 1;
      if (t == 3) begin ce = 1; li = 1; end
      case (op)
        4'b0000: begin
          if (t == 4) begin ei = 1; lm = 1; end
          if (t == 5) begin ce = 1; la = 1; end
        end
        4'b0001, 4'b0010: begin
          if (t == 4) begin ei = 1; lm = 1; end
          if (t == 5) begin ce = 1; lb = 1; su = (op == 4'b0010); end
          if (t == 6) begin eu = 1; la = 1; su = (op == 4'b0010); end
        end
        4'b1110: if (t == 4) begin ea = 1; lo = 1; end
        4'b1111: if (t == 4) h = 1;
        default: ;
      endcase
    end
    // Active-low lines are inverted when packed.
    return {cp, ep, ~lm, ~ce, ~li, ~ei, ~la, ea, su, eu, ~lb, ~lo, h};
  endfunction

  function automatic logic [5:0] model_tstate(int t, bit halted);
    logic [5:0] v = 6'b0;
    if (!halted) v[t-1] = 1'b1;
    return v;
  endfunction

  // One clock: drive inputs at negedge, check the combinational outputs, then
  // advance the model on the rising edge.
  task automatic applyStimulus(input bit clr_n, input bit run, input logic [3:0] op, input string tag);
    @(negedge CLK);
    CLR_bar     = clr_n;
    RUN         = run;
    instruction = op;
    #1;
    if (m_t >= 1) begin
      checkOutput({tag, ".ctrl"},
                  {19'b0, Cp, Ep, L_M_bar, CE_bar, L_I_bar, E_I_bar, L_A_bar, E_A, S_U, E_U, L_B_bar, L_O_bar, HLT},
                  {19'b0, model_word(m_t, m_halted, run, op)});
      checkOutput({tag, ".T_state"}, {26'b0, T_state}, {26'b0, model_tstate(m_t, m_halted)});
    end
    @(posedge CLK);
    if (!clr_n) begin
      m_t = 1;
      m_halted = 1'b0;
    end else if (!m_halted && run) begin
      if (m_t == 4 && op == 4'b1111) m_halted = 1'b1;
      else m_t = (m_t % 6) + 1;
    end
  endtask

  // Runs a full six-cycle instruction with garbage on the opcode during fetch.
  task automatic runInstruction(input logic [3:0] op, input string tag);
    for (int i = 0; i < 6; i++) begin
      logic [3:0] drv;
      drv = (m_t <= 3) ? 4'($urandom) : op;
      applyStimulus(1'b1, 1'b1, drv, tag);
    end
  endtask

  initial begin
    CLR_bar     = 1'b0;
    RUN         = 1'b1;
    instruction = 4'b0000;
    // The model is undefined before the first reset; hold reset without checking.
    m_t = 0;
    @(posedge CLK);
    m_t = 1;
    m_halted = 1'b0;

    applyStimulus(1'b0, 1'b1, 4'b0000, "reset");
    runInstruction(4'b0000, "lda");
    runInstruction(4'b0001, "add");
    runInstruction(4'b0010, "sub");
    runInstruction(4'b1110, "out");
    runInstruction(4'b0101, "nop");

    // Freeze in T2 for three cycles, then resume.
    applyStimulus(1'b1, 1'b1, 4'b0000, "frz_t1");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'b0000, "frz_hold");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 4'b0000, "frz_resume");
    // Now in T5: reset mid-instruction.
    applyStimulus(1'b0, 1'b1, 4'b0001, "midreset");
    applyStimulus(1'b1, 1'b1, 4'b0001, "after_midreset");
    applyStimulus(1'b1, 1'b1, 4'b0001, "t2");
    applyStimulus(1'b1, 1'b1, 4'b0001, "t3");
    applyStimulus(1'b1, 1'b1, 4'b1111, "hlt_t4");
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'($urandom), 4'($urandom), "halted");
    applyStimulus(1'b0, 1'b0, 4'b0000, "halt_clear");
    applyStimulus(1'b1, 1'b1, 4'b0000, "post_halt_t1");

    // Random traffic: mostly running, occasional freezes and resets.
    for (int i = 0; i < 3000; i++) begin
      bit         clr_n;
      bit         run;
      logic [3:0] op;
      clr_n = ($urandom_range(0, 39) != 0);
      run   = ($urandom_range(0, 9) > 1);
      case ($urandom_range(0, 7))
        0: op = 4'b0000;
        1: op = 4'b0001;
        2: op = 4'b0010;
        3: op = 4'b1110;
        4: op = 4'b1111;
        default: op = 4'($urandom);
      endcase
      applyStimulus(clr_n, run, op, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sap1_controller_sequencer.md
Name: sap1_controller_sequencer

Overview:
Control unit for the SAP-1 datapath. It runs a six-state ring counter (T1..T6) and decodes the opcode nibble from the instruction register. From these it drives the 12-bit control word (Cp Ep L_M_bar CE_bar L_I_bar E_I_bar L_A_bar E_A S_U E_U L_B_bar L_O_bar) that sequences the program counter, MAR, RAM, instruction register, accumulator, adder/subtracter, B register and output register. It also latches the halt condition.

Parameters:
OP_LDA, 4'b0000, load-accumulator opcode
OP_ADD, 4'b0001, add opcode
OP_SUB, 4'b0010, subtract opcode
OP_OUT, 4'b1110, output opcode
OP_HLT, 4'b1111, halt opcode

Ports:
CLK  input  1  system clock; all state changes on rising edge
CLR_bar  input  1  reset; synchronous, active-low
RUN  input  1  1 = sequencer advances; 0 = state frozen, control word forced inactive
instruction  input  4  opcode nibble from instruction register
Cp  output  1  PC increment (active high)
Ep  output  1  PC output enable (active high)
L_M_bar  output  1  MAR load (active low)
CE_bar  output  1  RAM output enable (active low)
L_I_bar  output  1  IR load (active low)
E_I_bar  output  1  IR address-nibble output enable (active low)
L_A_bar  output  1  accumulator load (active low)
E_A  output  1  accumulator output enable (active high)
S_U  output  1  1 = subtract, 0 = add
E_U  output  1  adder/subtracter output enable (active high)
L_B_bar  output  1  B register load (active low)
L_O_bar  output  1  output register load (active low)
HLT  output  1  halt indicator (active high)
T_state  output  6  one-hot ring state, bit0 = T1 ... bit5 = T6; all-zero when halted

Behaviour:
- State register: one-hot T1..T6 plus a HALTED state. Control outputs and HLT are combinational decodes of the state register, instruction and RUN.
- Inactive control word: Cp=0, Ep=0, E_A=0, S_U=0, E_U=0; every *_bar output = 1.
- Reset: CLR_bar=0 at a rising edge -> state = T1, from any state including HALTED and mid-instruction. Reset has priority over RUN and halt. After reset, outputs show the T1 decode (Ep=1, L_M_bar=0, rest inactive, HLT=0, T_state=6'b000001) whenever RUN=1.
- Advance: with RUN=1, each edge moves T1->T2->...->T6->T1. One instruction takes 6 clocks.
- RUN=0: state holds, all control outputs inactive, T_state still shows the held state. The sequence resumes in the same T state when RUN returns to 1.
- Fetch, opcode-independent:
  - T1: Ep=1, L_M_bar=0.
  - T2: Cp=1.
  - T3: CE_bar=0, L_I_bar=0.
- Execute, decoded from instruction, which is valid from T4 onward:
  - LDA: T4 E_I_bar=0, L_M_bar=0; T5 CE_bar=0, L_A_bar=0; T6 inactive.
  - ADD: T4 E_I_bar=0, L_M_bar=0; T5 CE_bar=0, L_B_bar=0; T6 E_U=1, L_A_bar=0, S_U=0.
  - SUB: same as ADD, except S_U=1 in T5 and T6.
  - OUT: T4 E_A=1, L_O_bar=0; T5 and T6 inactive.
  - HLT: T4 control word inactive and HLT=1 combinationally; the next edge enters HALTED.
  - Any other opcode: T4..T6 inactive (NOP); the ring continues.
- HALTED: all controls inactive, HLT=1, T_state=0. RUN is ignored. Only CLR_bar=0 exits, to T1.
- Instruction changes during T1..T3 have no effect on outputs.

Test Plan:
- Reset/fetch: CLR_bar=0 for 1 edge, RUN=1 -> T_state 000001, 000010, 000100 on successive cycles; Ep=1/L_M_bar=0 in T1, Cp=1 in T2, CE_bar=0/L_I_bar=0 in T3; all other outputs inactive.
- LDA then ADD: instruction=0000 over 6 cycles, then 0001 -> T4/T5 decodes as specified; the ADD cycle's T6 shows E_U=1, L_A_bar=0, S_U=0; the ring wraps to T1 after T6.
- SUB and OUT: instruction=0010 -> S_U=1 in T5 and T6 with E_U=1 in T6; instruction=1110 -> E_A=1, L_O_bar=0 only in T4.
- Halt: instruction=1111 -> HLT=1 in T4; from the next edge T_state=0, HLT=1, controls inactive for 10+ cycles with RUN toggling; CLR_bar=0 -> T1 and HLT=0.
- RUN freeze and mid-reset: RUN=0 in T2 for 3 cycles -> T_state stays 000010, Cp=0; RUN=1 -> Cp=1, then T3. CLR_bar=0 during T5 -> T1 on the next edge.
- Undefined opcode 0101 -> T4..T6 fully inactive, then T1 follows.
